// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - multi-cycle MULT/DIV sequencer owning all HI/LO register writes
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2:0]         op_i,
    input  logic [WIDTH-1:0]   rs_val_i,
    input  logic [WIDTH-1:0]   rt_val_i,
    input  logic               cancel_i,
    output logic               busy_o,
    output logic [1:0]         hilo_we_o,
    output logic [2*WIDTH-1:0] hilo_wdata_o
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [5:0]           cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    logic                 is_div_q, is_div_d;
    logic                 busy_q;
    logic [1:0]           we_q, we_d;
    logic [2*WIDTH-1:0]   wdata_q, wdata_d;

    logic                 op_signed, rs_neg, rt_neg;
    logic [WIDTH-1:0]     rs_mag, rt_mag, q_fix, r_fix;
    logic [WIDTH:0]       mul_sum, div_diff;
    logic [2*WIDTH-1:0]   prod_fix;

    assign op_signed = ~op_i[0];
    assign rs_neg    = op_signed & rs_val_i[WIDTH-1];
    assign rt_neg    = op_signed & rt_val_i[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_val_i : rs_val_i;
    assign rt_mag    = rt_neg ? -rt_val_i : rt_val_i;

    // acc holds product (MUL) or {partial remainder, dividend/quotient} (DIV)
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : {WIDTH{1'b0}})};
    assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opa_q};

    assign q_fix    = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign r_fix    = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_lo_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        we_d     = 2'b00;
        wdata_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !cancel_i) begin
                    case (op_i)
                        3'b000, 3'b001: begin
                            opa_d    = rs_mag;
                            opb_d    = rt_mag;
                            neg_lo_d = rs_neg ^ rt_neg;
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        3'b010, 3'b011: begin
                            is_div_d = 1'b1;
                            cnt_d    = '0;
                            if (rt_val_i == '0) begin
                                acc_d    = {rs_val_i, {WIDTH{1'b1}}};
                                neg_lo_d = 1'b0;
                                neg_hi_d = 1'b0;
                                state_d  = S_FIX;
                            end else begin
                                opa_d    = rt_mag;
                                acc_d    = {{WIDTH{1'b0}}, rs_mag};
                                neg_lo_d = rs_neg ^ rt_neg;
                                neg_hi_d = rs_neg;
                                state_d  = S_DIV;
                            end
                        end
                        3'b100: begin
                            we_d    = 2'b10;
                            wdata_d = {rs_val_i, {WIDTH{1'b0}}};
                            state_d = S_DONE;
                        end
                        3'b101: begin
                            we_d    = 2'b01;
                            wdata_d = {{WIDTH{1'b0}}, rs_val_i};
                            state_d = S_DONE;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH-1)) state_d = S_FIX;
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                we_d    = 2'b11;
                wdata_d = is_div_q ? {r_fix, q_fix} : prod_fix;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (cancel_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            we_d    = 2'b00;
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 2'b00;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            busy_q   <= (state_d != S_IDLE);
            we_q     <= we_d;
            wdata_q  <= wdata_d;
        end
    end

    // a flush arriving during DONE must still kill the already-registered write
    assign busy_o       = busy_q;
    assign hilo_we_o    = cancel_i ? 2'b00 : we_q;
    assign hilo_wdata_o = wdata_q;
endmodule
